// File: rtl/song_recorder.sv
// song_recorder: records timestamped note events into RAM and replays them as note strobes timed by beat ticks.
// Optional feature macro: LOOP_PLAYBACK_EN (defined: playback wraps to entry 0 and repeats; undefined: stops after last entry).
// Ports:
//   clk                 system clock
//   reset               asynchronous active-high reset, discards the song
//   state               mode: 00 JAM_SESH, 01 COMPOSER, 10 SONG_PLAYER, 11 JAM_SESH
//   done_recording      one-cycle pulse ending a recording
//   note_in             key index of the pressed note
//   note_strobe         one-cycle pulse qualifying note_in
//   beat_tick           one-cycle timing pulse
//   finished_recording  one-cycle pulse when the RAM fills during record
//   play_note           replayed key index, held between strobes
//   play_strobe         one-cycle pulse qualifying play_note
//   song_len            number of valid entries (0..DEPTH)
module song_recorder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DUR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            state,
    input  logic                  done_recording,
    input  logic [5:0]            note_in,
    input  logic                  note_strobe,
    input  logic                  beat_tick,
    output logic                  finished_recording,
    output logic [5:0]            play_note,
    output logic                  play_strobe,
    output logic [ADDR_WIDTH:0]   song_len
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int EW = 6 + DUR_WIDTH;
    localparam logic [DUR_WIDTH-1:0] DMAX = '1;
`ifdef LOOP_PLAYBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REC, P_FETCH, P_WAIT, P_DONE} fsm_t;
    fsm_t fsm, fsm_nxt;

    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         rd_q;
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   wr_count;
    logic [DUR_WIDTH-1:0]  delta, wait_cnt, cur_cnt;
    logic [5:0]            note_q;
    logic                  loaded;
    logic                  rec_mode, play_mode, wr_en, last_slot, rec_exit, emit, last_entry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) fsm <= IDLE;
        else       fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    fsm_nxt = rec_mode ? REC : play_mode ? (song_len == '0 ? P_DONE : P_FETCH) : IDLE;
            REC:     fsm_nxt = rec_exit ? IDLE : REC;
            P_FETCH: fsm_nxt = play_mode ? P_WAIT : IDLE;
            P_WAIT:  fsm_nxt = !play_mode ? IDLE : !emit ? P_WAIT : (last_entry && !LOOP) ? P_DONE : P_FETCH;
            P_DONE:  fsm_nxt = play_mode ? P_DONE : IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        rec_mode    = state == 2'b01;
        play_mode   = state == 2'b10;
        wr_en       = fsm == REC && rec_mode && note_strobe;
        last_slot   = wr_ptr == ADDR_WIDTH'(DEPTH - 1);
        wr_count    = {1'b0, wr_ptr} + {{ADDR_WIDTH{1'b0}}, wr_en};
        // A note arriving with done_recording is written and counted before leaving
        rec_exit    = fsm == REC && (!rec_mode || done_recording || (wr_en && last_slot));
        // First wait cycle takes the delta straight from the freshly read entry
        cur_cnt     = loaded ? wait_cnt : rd_q[DUR_WIDTH-1:0];
        emit        = fsm == P_WAIT && play_mode && (cur_cnt == '0 || (cur_cnt == DUR_WIDTH'(1) && beat_tick));
        last_entry  = ({1'b0, rd_ptr} + (ADDR_WIDTH+1)'(1)) == song_len;
        play_strobe = emit;
        play_note   = emit ? rd_q[EW-1:DUR_WIDTH] : note_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            delta              <= '0;
            wait_cnt           <= '0;
            loaded             <= 1'b0;
            note_q             <= '0;
            song_len           <= '0;
            finished_recording <= 1'b0;
        end else begin
            finished_recording <= wr_en && last_slot;
            loaded             <= fsm == P_WAIT;
            if (fsm == IDLE) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                delta  <= '0;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                delta  <= {{(DUR_WIDTH-1){1'b0}}, beat_tick};
            end else if (fsm == REC && beat_tick && delta != DMAX) begin
                delta <= delta + DUR_WIDTH'(1);
            end
            if (rec_exit) song_len <= wr_count;
            if (fsm == P_WAIT) wait_cnt <= (beat_tick && cur_cnt != '0) ? cur_cnt - DUR_WIDTH'(1) : cur_cnt;
            if (emit) begin
                note_q <= rd_q[EW-1:DUR_WIDTH];
                rd_ptr <= last_entry ? '0 : rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    // Song RAM: synchronous write, registered read issued from P_FETCH
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {note_in, delta};
        if (fsm == P_FETCH) rd_q <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_song_recorder.sv
// tb_song_recorder: directed and randomized checks of song_recorder against a queue-based song model.
module tb_song_recorder;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int DMAX = 255;
`ifdef LOOP_PLAYBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [1:0] state;
    logic done_recording, note_strobe, beat_tick;
    logic [5:0] note_in;
    logic finished_recording, play_strobe;
    logic [5:0] play_note;
    logic [AW:0] song_len;
    logic [1:0] s_state;
    logic s_done, s_strobe;
    logic [5:0] s_note;
    logic s_fin, s_pstrobe;
    logic [5:0] s_pnote;
    logic [2:0] s_len;

    int checks = 0;
    int errors = 0;
    int q_note[$];
    int q_delta[$];
    int r_note[16];
    int r_gap[16];
    logic [5:0] last_note;

    song_recorder #(.ADDR_WIDTH(AW), .DUR_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .state(state), .done_recording(done_recording),
        .note_in(note_in), .note_strobe(note_strobe), .beat_tick(beat_tick),
        .finished_recording(finished_recording), .play_note(play_note),
        .play_strobe(play_strobe), .song_len(song_len)
    );

    song_recorder #(.ADDR_WIDTH(2), .DUR_WIDTH(DW)) dut_s (
        .clk(clk), .reset(reset), .state(s_state), .done_recording(s_done),
        .note_in(s_note), .note_strobe(s_strobe), .beat_tick(beat_tick),
        .finished_recording(s_fin), .play_note(s_pnote),
        .play_strobe(s_pstrobe), .song_len(s_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Records n notes from r_note/r_gap: r_gap[k] ticked cycles precede note k.
    task automatic record(input int n, input bit rand_co, input bit done_with_last);
        int tc;
        int tm;
        nxt();
        state = 2'b01; beat_tick = 1'b0; note_strobe = 1'b0; done_recording = 1'b0;
        nxt();
        tc = 0; tm = 0;
        q_note.delete(); q_delta.delete();
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < r_gap[k]; g++) begin
                beat_tick = 1'b1;
                #1 chk("rec_fin", finished_recording, 0);
                tc++;
                nxt();
                if (rand_co && $urandom_range(0, 1) == 1) begin
                    beat_tick = 1'b0;
                    nxt();
                end
            end
            beat_tick = rand_co ? 1'($urandom_range(0, 1)) : 1'b0;
            note_strobe = 1'b1;
            note_in = 6'(r_note[k]);
            done_recording = done_with_last && k == n - 1;
            q_note.push_back(r_note[k]);
            q_delta.push_back(tc - tm > DMAX ? DMAX : tc - tm);
            tm = tc;
            if (beat_tick) tc++;
            nxt();
            note_strobe = 1'b0; done_recording = 1'b0; beat_tick = 1'b0;
        end
        if (!done_with_last) begin
            done_recording = 1'b1;
            nxt();
            done_recording = 1'b0;
        end
        state = 2'b00;
        #1 chk("rec_len", song_len, q_note.size());
        chk("rec_fin_end", finished_recording, 0);
    endtask

    // Plays for n cycles; expected strobe cycles derived from tick counts per entry window.
    task automatic play(input int n, input int tick_pct);
        bit t[];
        bit es[];
        int en[];
        int start, i, c, need, len;
        t = new[n]; es = new[n]; en = new[n];
        for (int k = 0; k < n; k++) begin
            t[k] = $urandom_range(0, 99) < tick_pct;
            es[k] = 1'b0;
            en[k] = 0;
        end
        len = q_note.size();
        start = 2;
        i = 0;
        while (len > 0 && start < n) begin
            c = start;
            need = q_delta[i % len];
            while (c < n && need > 0) begin
                if (t[c]) need--;
                if (need > 0) c++;
            end
            if (c >= n) break;
            es[c] = 1'b1;
            en[c] = q_note[i % len];
            i++;
            if (!LOOP && i == len) break;
            start = c + 2;
        end
        for (int k = 0; k < n; k++) begin
            state = 2'b10;
            beat_tick = t[k];
            #1;
            chk("play_strobe", play_strobe, es[k]);
            if (es[k]) last_note = 6'(en[k]);
            chk("play_note", play_note, last_note);
            chk("play_fin", finished_recording, 0);
            nxt();
        end
        state = 2'b00;
        beat_tick = 1'b1;
        #1 chk("play_exit_strobe", play_strobe, 0);
        nxt();
        beat_tick = 1'b0;
        #1 chk("play_idle_strobe", play_strobe, 0);
    endtask

    initial begin
        reset = 1'b1; state = 2'b00; done_recording = 1'b0; note_strobe = 1'b0;
        beat_tick = 1'b0; note_in = '0;
        s_state = 2'b00; s_done = 1'b0; s_strobe = 1'b0; s_note = '0;
        last_note = '0;
        nxt(); nxt();
        chk("rst_len", song_len, 0);
        chk("rst_strobe", play_strobe, 0);
        chk("rst_note", play_note, 0);
        chk("rst_fin", finished_recording, 0);
        chk("rst_s_len", s_len, 0);
        reset = 1'b0;
        nxt();

        // Small RAM fills: exactly one finished_recording pulse, len = DEPTH
        s_state = 2'b01;
        nxt();
        for (int k = 0; k < 4; k++) begin
            s_strobe = 1'b1;
            s_note = 6'(k + 1);
            #1 chk("fill_fin_early", s_fin, 0);
            nxt();
            s_strobe = 1'b0;
            if (k < 3) begin
                #1 chk("fill_fin_gap", s_fin, 0);
                nxt();
            end
        end
        s_state = 2'b00;
        s_strobe = 1'b1;
        #1 chk("fill_fin_pulse", s_fin, 1);
        chk("fill_len", s_len, 4);
        chk("fill_no_play", s_pstrobe, 0);
        nxt();
        s_strobe = 1'b0;
        #1 chk("fill_fin_once", s_fin, 0);
        chk("fill_len_hold", s_len, 4);
        nxt();
        chk("fill_fin_off", s_fin, 0);
        chk("fill_len_idle", s_len, 4);
        chk("fill_pnote", s_pnote, 0);

        // Directed song: 28 after 3 ticks, 30 after 2 ticks
        r_note[0] = 28; r_gap[0] = 3; r_note[1] = 30; r_gap[1] = 2;
        record(2, 1'b0, 1'b0);
        chk("t1_len", song_len, 2);
        done_recording = 1'b1;
        nxt();
        done_recording = 1'b0;
        #1 chk("done_idle_ignored", song_len, 2);
        play(20, 100);

        // Leave mid-wait, then re-enter from entry 0
        play(7, 100);
        play(20, 100);

        // Saturated delta and note coinciding with done_recording
        r_note[0] = 12; r_gap[0] = 300; r_note[1] = 40; r_gap[1] = 1;
        record(2, 1'b0, 1'b1);
        chk("t4_len", song_len, 2);
        play(300, 100);

        // Randomized songs and tick patterns
        for (int it = 0; it < 8; it++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin
                r_note[k] = $urandom_range(1, 51);
                r_gap[k] = $urandom_range(0, 4);
            end
            record(n, 1'b1, 1'($urandom_range(0, 1)));
            play(60, 50);
        end

        // Reset mid-record discards the song
        state = 2'b01;
        nxt();
        note_strobe = 1'b1; note_in = 6'd33;
        nxt();
        note_strobe = 1'b0; beat_tick = 1'b1;
        nxt();
        chk("t5_len_kept", song_len, q_note.size());
        reset = 1'b1;
        #1 chk("t5r_len", song_len, 0);
        chk("t5r_note", play_note, 0);
        chk("t5r_strobe", play_strobe, 0);
        chk("t5r_fin", finished_recording, 0);
        nxt();
        reset = 1'b0; state = 2'b00; beat_tick = 1'b0;
        q_note.delete(); q_delta.delete(); last_note = '0;
        nxt();
        play(30, 100);

        // Reset while a strobe is high
        r_note[0] = 50; r_gap[0] = 0;
        record(1, 1'b0, 1'b0);
        state = 2'b10; beat_tick = 1'b0;
        nxt(); nxt();
        chk("t5p_strobe_pre", play_strobe, 1);
        chk("t5p_note_pre", play_note, 50);
        reset = 1'b1;
        #1 chk("t5p_strobe", play_strobe, 0);
        chk("t5p_note", play_note, 0);
        chk("t5p_len", song_len, 0);
        chk("t5p_fin", finished_recording, 0);
        nxt();
        reset = 1'b0; state = 2'b00;
        q_note.delete(); q_delta.delete(); last_note = '0;
        nxt();
        play(30, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
